mem_stage: RTL

Memory-access stage of the 16-bit MIPS pipeline, between the execute stage (upstream) and write-back (downstream). Takes the ALU result as address plus store data and control, drives the data memory's write-enable/data/address ports, captures load data from its combinational read port, and holds the result in a MEM/WB pipeline register. It uses valid/ready handshakes on both sides and supports flush. Out-of-range addresses raise a fault instead of touching memory.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_stage_sat_counter.sv | 26 ++
 rtl/mem_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: operation decode, MEM/WB record, occupancy states.
package mem_pkg;

  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned MEM_DM_AW  = 6;
  localparam int unsigned MEM_RD_W   = 3;
  localparam int unsigned MEM_CNT_W  = 16;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_LOAD,
    MEM_STORE,
    MEM_FAULT
  } mem_op_t;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } wb_state_t;

  typedef struct packed {
    logic                  reg_write;
    logic [MEM_RD_W-1:0]   rd;
    logic [MEM_DATA_W-1:0] data;
    logic                  fault;
  } memwb_rec_t;

  // A fault dominates; a combined read/write in range captures load data.
  function automatic mem_op_t mem_decode(input logic rd, input logic wr, input logic fault);
    mem_op_t op;
    op = MEM_NONE;
    if (fault)   op = MEM_FAULT;
    else if (rd) op = MEM_LOAD;
    else if (wr) op = MEM_STORE;
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_sat_counter.sv
// Saturating event counter with synchronous clear that overrides increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_stage.sv
// MIPS-16 memory-access stage with MEM/WB register, valid/ready handshake and flush.
// Optional build macro MEM_STATS_EN adds load/store statistics counters.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = MEM_DATA_W,
  parameter int unsigned DM_ADDRESS_WIDTH = MEM_DM_AW,
  parameter int unsigned REG_ADDR_WIDTH   = MEM_RD_W,
  parameter int unsigned CNT_WIDTH        = MEM_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mem_read,
  input  logic                        in_mem_write,
  input  logic                        in_reg_write,
  input  logic [DATA_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]       in_store_data,
  input  logic [REG_ADDR_WIDTH-1:0]   in_rd,
  input  logic                        flush,
  output logic                        dm_we,
  output logic [DATA_WIDTH-1:0]       dm_D,
  output logic [DM_ADDRESS_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0]       dm_Q,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_reg_write,
  output logic [REG_ADDR_WIDTH-1:0]   out_rd,
  output logic [DATA_WIDTH-1:0]       out_data,
`ifdef MEM_STATS_EN
  input  logic                        stats_clr,
  output logic [CNT_WIDTH-1:0]        load_count,
  output logic [CNT_WIDTH-1:0]        store_count,
`endif
  output logic                        out_fault
);

  wb_state_t  r_state;
  wb_state_t  w_state_nxt;
  memwb_rec_t r_rec;
  memwb_rec_t w_rec_nxt;
  mem_op_t    w_op;
  logic       w_accept;
  logic       w_out_of_range;
  logic       w_fault;

  assign out_valid = (r_state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;

  // Reset also blocks acceptance so no write can leak out while rst_n is low.
  assign w_accept       = rst_n && in_valid && in_ready && !flush;
  assign w_out_of_range = (in_addr[DATA_WIDTH-1:DM_ADDRESS_WIDTH] != '0);
  assign w_fault        = w_accept && w_out_of_range && (in_mem_read || in_mem_write);
  assign w_op           = mem_decode(in_mem_read, in_mem_write, w_fault);

  assign dm_addr = in_addr[DM_ADDRESS_WIDTH-1:0];
  assign dm_D    = in_store_data;
  assign dm_we   = w_accept && in_mem_write && !w_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Flush wins over accept and consume; a held entry stays until consumed.
  always_comb begin
    w_state_nxt = r_state;
    if (flush)          w_state_nxt = ST_EMPTY;
    else if (w_accept)  w_state_nxt = ST_FULL;
    else if (out_ready) w_state_nxt = ST_EMPTY;
  end

  always_comb begin
    w_rec_nxt           = '0;
    w_rec_nxt.reg_write = in_reg_write && !w_fault;
    w_rec_nxt.rd        = MEM_RD_W'(in_rd);
    w_rec_nxt.fault     = w_fault;
    case (w_op)
      MEM_LOAD:  w_rec_nxt.data = MEM_DATA_W'(dm_Q);
      MEM_FAULT: w_rec_nxt.data = '0;
      default:   w_rec_nxt.data = MEM_DATA_W'(in_addr);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_rec <= '0;
    else if (w_accept) r_rec <= w_rec_nxt;
  end

  assign out_reg_write = r_rec.reg_write;
  assign out_rd        = REG_ADDR_WIDTH'(r_rec.rd);
  assign out_data      = DATA_WIDTH'(r_rec.data);
  assign out_fault     = r_rec.fault;

`ifdef MEM_STATS_EN
  logic w_load_ok;
  logic w_store_ok;

  assign w_load_ok  = w_accept && in_mem_read && !w_fault;
  assign w_store_ok = w_accept && in_mem_write && !w_fault;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_load_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_load_ok),
    .i_clr   (stats_clr),
    .o_count (load_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_store_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_store_ok),
    .i_clr   (stats_clr),
    .o_count (store_count)
  );
`endif

endmodule
